knn_mem_read_master: RTL and testbench

- Avalon-MM pipelined read master; the initiator side of the single-port on-chip memory slave (32-bit data, 12-bit word address).
- Fetches a block of training/feature words (base, length) and delivers them in order on a valid/ready stream to the KNN distance datapath.
- Sits between the Nios-visible on-chip RAM and the accelerator core.
- Credit-based flow control guarantees no read data is lost when the consumer stalls.

---
 rtl/knn_mem_pkg.sv | 15 +
 rtl/knn_sync_fifo.sv | 63 ++++++
 rtl/knn_mem_read_master.sv | 165 ++++++++++++++++
 tb/tb_knn_mem_read_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_mem_pkg.sv
// Shared defaults and state encoding for the KNN memory read master.
package knn_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 12;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned LEN_W_DEF      = 13;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/knn_sync_fifo.sv
// First-word fall-through synchronous FIFO; head is visible whenever count is non-zero.
module knn_sync_fifo
  import knn_mem_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot, so a push into a full FIFO is legal in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/knn_mem_read_master.sv
// Avalon-MM pipelined read master: fetches (base, len) words and streams them in order,
// issuing a request only when FIFO space is reserved for its response.
module knn_mem_read_master
  import knn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CR_W  = CNT_W + 1;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [LEN_W-1:0]  issue_cnt_nxt;
  logic [LEN_W-1:0]  pop_cnt_nxt;
  logic [CR_W-1:0]   credits_nxt;

  assign accept        = read_q & ~avm_waitrequest;
  assign fifo_push     = avm_readdatavalid & (state_q != IDLE);
  assign fifo_pop      = st_valid & st_ready;
  assign issue_cnt_nxt = issue_cnt_q + LEN_W'(accept);
  assign pop_cnt_nxt   = pop_cnt_q + LEN_W'(fifo_pop);
  // Slots held next cycle: buffered words plus requests still awaiting data.
  assign credits_nxt   = CR_W'(fifo_count) + CR_W'(outst_q) + CR_W'(accept) - CR_W'(fifo_pop);

  knn_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .data_i  (avm_readdata),
    .pop_i   (fifo_pop),
    .data_o  (st_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign st_valid       = ~fifo_empty;
  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_byteenable = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_start && (cmd_len != '0)) state_d = ISSUE;
      ISSUE:   if (issue_cnt_nxt == len_q)      state_d = DRAIN;
      DRAIN:   if (pop_cnt_nxt == len_q)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    read_d      = 1'b0;
    outst_d     = outst_q + CNT_W'(accept) - CNT_W'(fifo_push);
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cmd_base;
            len_d       = cmd_len;
            issue_cnt_d = '0;
            pop_cnt_d   = '0;
            busy_d      = 1'b1;
          end
        end
      end
      ISSUE, DRAIN: begin
        issue_cnt_d = issue_cnt_nxt;
        pop_cnt_d   = pop_cnt_nxt;
        if (accept) addr_d = addr_q + ADDR_W'(1);
        if ((state_q == DRAIN) && (pop_cnt_nxt == len_q)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A stalled request stays on the bus unchanged until the slave takes it.
    if (read_q && avm_waitrequest) begin
      read_d = 1'b1;
    end else begin
      read_d = (state_d == ISSUE) && (issue_cnt_d < len_d) &&
               (credits_nxt < CR_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      outst_q     <= '0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      outst_q     <= outst_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_knn_mem_read_master.sv
// Directed bench: table of transfers against a behavioural Avalon slave, plus reset/zero-length/ignored-start sequences.
module tb_knn_mem_read_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start;
  logic [11:0] cmd_base;
  logic [12:0] cmd_len;
  logic        busy, done;
  logic [11:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest   = 1'b0;
  logic [31:0] avm_readdata      = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  always #5 clk = ~clk;

  knn_mem_read_master dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_start         (cmd_start),
    .cmd_base          (cmd_base),
    .cmd_len           (cmd_len),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {4'hA, a, 4'h5, a};
  endfunction

  // Behavioural slave: accepts when not stalled, answers in order after 'lat' cycles.
  typedef struct { int due; logic [11:0] addr; } rd_t;
  rd_t rq[$];
  int  cyc     = 0;
  int  lat     = 1;
  bit  wr_rand = 1'b0;

  always @(negedge clk) begin
    avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEEF;
    end
    #2;
    if (avm_read && !avm_waitrequest) rq.push_back('{due: cyc + lat, addr: avm_address});
    cyc++;
  end

  // Bus and stream monitor, sampled mid-cycle.
  int          acc_cnt = 0, pop_cnt = 0, done_cnt = 0, first_acc = 0, last_acc = 0;
  logic [11:0] exp_iss = '0, exp_rd = '0, last_addr = '0, prev_addr = '0;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    #3;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_read", 32'(avm_read), 32'd1);
        check("hold_addr", 32'(avm_address), 32'(prev_addr));
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (avm_read && !avm_waitrequest) begin
        check("req_addr", 32'(avm_address), 32'(exp_iss));
        exp_iss   = exp_iss + 12'd1;
        last_addr = avm_address;
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end
      if (st_valid && st_ready) begin
        check("st_data", st_data, mem_word(exp_rd));
        exp_rd = exp_rd + 12'd1;
        pop_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    int          lat;
    bit          wr_rand;
    bit          ready_hold;
    logic [11:0] exp_last_addr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit got;
    lat     = v.lat;
    wr_rand = v.wr_rand;
    @(negedge clk);
    st_ready  = !v.ready_hold;
    exp_iss   = v.base;
    exp_rd    = v.base;
    acc_cnt   = 0;
    pop_cnt   = 0;
    done_cnt  = 0;
    cmd_start = 1'b1;
    cmd_base  = v.base;
    cmd_len   = v.len;
    @(negedge clk);
    cmd_start = 1'b0;
    #4;
    check("start_busy", 32'(busy), 32'd1);
    check("start_read", 32'(avm_read), 32'd1);
    if (v.ready_hold) begin
      repeat (3) @(negedge clk);
      cmd_start = 1'b1;
      cmd_base  = 12'h300;
      cmd_len   = 13'd3;
      @(negedge clk);
      cmd_start = 1'b0;
      repeat (20) @(negedge clk);
      #4;
      check("credit_acc", 32'(acc_cnt), 32'd8);
      check("credit_read", 32'(avm_read), 32'd0);
      check("credit_valid", 32'(st_valid), 32'd1);
      @(negedge clk);
      st_ready = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #4;
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("done_busy_low", 32'(busy), 32'd0);
    check("n_issued", 32'(acc_cnt), 32'(v.len));
    check("n_popped", 32'(pop_cnt), 32'(v.len));
    check("last_addr", 32'(last_addr), 32'(v.exp_last_addr));
    check("no_outstanding", 32'(rq.size()), 32'd0);
    if (!v.wr_rand && !v.ready_hold)
      check("back_to_back", 32'(last_acc - first_acc), 32'(v.len) - 32'd1);
    @(negedge clk);
    #4;
    check("done_one_cycle", 32'(done), 32'd0);
    check("st_empty", 32'(st_valid), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vec_t post;
    bit   got;
    vecs[0] = '{12'h010, 13'd4,  1, 1'b0, 1'b0, 12'h013};
    vecs[1] = '{12'h100, 13'd20, 1, 1'b0, 1'b1, 12'h113};
    vecs[2] = '{12'hFFE, 13'd4,  1, 1'b0, 1'b0, 12'h001};
    vecs[3] = '{12'h200, 13'd16, 3, 1'b1, 1'b0, 12'h20F};
    post    = '{12'h080, 13'd2,  1, 1'b0, 1'b0, 12'h081};

    reset_n   = 1'b0;
    cmd_start = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    st_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_valid", 32'(st_valid), 32'd0);
    check("byteenable", 32'(avm_byteenable), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #4;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_read", 32'(avm_read), 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Zero-length command: done next cycle, no bus traffic, never busy.
    wr_rand = 1'b0;
    lat     = 1;
    @(negedge clk);
    acc_cnt   = 0;
    done_cnt  = 0;
    cmd_start = 1'b1;
    cmd_base  = 12'h555;
    cmd_len   = 13'd0;
    @(negedge clk);
    cmd_start = 1'b0;
    #4;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_read", 32'(avm_read), 32'd0);
    @(negedge clk);
    #4;
    check("len0_done_clr", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    #4;
    check("len0_no_req", 32'(acc_cnt), 32'd0);
    check("len0_done_cnt", 32'(done_cnt), 32'd1);

    // Reset in the middle of a transfer with responses still in flight.
    lat = 3;
    @(negedge clk);
    st_ready  = 1'b1;
    exp_iss   = 12'h040;
    exp_rd    = 12'h040;
    acc_cnt   = 0;
    pop_cnt   = 0;
    cmd_start = 1'b1;
    cmd_base  = 12'h040;
    cmd_len   = 13'd10;
    @(negedge clk);
    cmd_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      #4;
      if (pop_cnt >= 5) got = 1'b1;
    end
    check("mid_reach5", 32'(got), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_read", 32'(avm_read), 32'd0);
    check("mid_rst_addr", 32'(avm_address), 32'd0);
    check("mid_rst_valid", 32'(st_valid), 32'd0);
    check("mid_late_pending", 32'(rq.size() > 0), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #4;
    check("late_rdv_ignored", 32'(st_valid), 32'd0);
    check("late_idle_busy", 32'(busy), 32'd0);
    check("late_drained", 32'(rq.size()), 32'd0);

    run_vec(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
